// File: rtl/l2_config_and_types.sv
// rtl/l2_config_and_types.sv - shared L2 coherence types and defaults
package l2_config_and_types;

    localparam int L2_NUM_PORTS          = 2;
    localparam int SNOOP_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        DONE  = 2'd2
    } snoop_state_t;

    typedef struct packed {
        logic        hit;
        logic        dirty;
        logic [31:0] data;
    } snoop_response_t;

endpackage

// File: rtl/l2_rr_priority.sv
// rtl/l2_rr_priority.sv - two-input round-robin picker
module l2_rr_priority (
    input  logic [1:0] i_request,
    input  logic       i_last_grant,
    output logic       o_grant_id,
    output logic       o_any_valid
);

    always_comb begin
        o_any_valid = |i_request;
        // On contention the core that did not win last time goes first.
        if (&i_request) begin
            o_grant_id = ~i_last_grant;
        end else begin
            o_grant_id = i_request[1];
        end
    end

endmodule

// File: rtl/l2_snoop_arbiter.sv
// rtl/l2_snoop_arbiter.sv - serialises dual-core coherence requests onto the snoop path
module l2_snoop_arbiter
    import l2_config_and_types::*;
#(
    parameter int NUM_CPUS      = L2_NUM_PORTS,
    parameter int SNOOP_TIMEOUT = SNOOP_TIMEOUT_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CPUS-1:0]      i_req_valid,
    input  logic [NUM_CPUS-1:0]      i_req_wnr,
    input  logic [NUM_CPUS-1:0][31:0] i_req_addr,
    output logic [NUM_CPUS-1:0]      o_req_ack,
    output logic                     o_resp_hit,
    output logic                     o_resp_data_valid,
    output logic [31:0]              o_resp_data,
    output logic [NUM_CPUS-1:0]      o_snoop_valid,
    output logic                     o_snoop_wnr,
    output logic [31:0]              o_snoop_addr,
    input  logic [NUM_CPUS-1:0]      i_snoop_ack,
    input  logic [NUM_CPUS-1:0]      i_snoop_hit,
    input  logic [NUM_CPUS-1:0]      i_snoop_dirty,
    input  logic [NUM_CPUS-1:0][31:0] i_snoop_data,
    output logic                     o_busy,
    output logic                     o_timeout_err
);

    localparam int CNT_W = $clog2(SNOOP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SNOOP_TIMEOUT - 1);

    snoop_state_t    r_state;
    snoop_state_t    w_next_state;
    logic            r_grant_id;
    logic            r_last_grant;
    logic            r_wnr;
    logic [31:0]     r_addr;
    logic [CNT_W-1:0] r_count;
    snoop_response_t r_resp;
    logic            r_timeout_err;

    logic            w_grant_id;
    logic            w_any_valid;
    logic            w_other;
    logic            w_ack;
    logic            w_timeout;

    l2_rr_priority u_rr (
        .i_request    (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant_id   (w_grant_id),
        .o_any_valid  (w_any_valid)
    );

    // Only the non-granted core may answer the snoop.
    assign w_other   = ~r_grant_id;
    assign w_ack     = i_snoop_ack[w_other];
    assign w_timeout = (r_count == CNT_MAX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_valid) w_next_state = SNOOP;
            SNOOP:   if (w_ack || w_timeout) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant_id    <= 1'b0;
            r_last_grant  <= 1'b1;
            r_wnr         <= 1'b0;
            r_addr        <= '0;
            r_count       <= '0;
            r_resp        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id   <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_wnr        <= i_req_wnr[w_grant_id];
                        r_addr       <= i_req_addr[w_grant_id];
                    end
                end
                SNOOP: begin
                    // An ack arriving on the final count beats the timeout.
                    if (w_ack) begin
                        r_resp.hit   <= i_snoop_hit[w_other];
                        r_resp.dirty <= i_snoop_dirty[w_other];
                        r_resp.data  <= i_snoop_data[w_other];
                    end else if (w_timeout) begin
                        r_resp        <= '0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_count <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_req_ack         = '0;
        o_snoop_valid     = '0;
        o_resp_hit        = 1'b0;
        o_resp_data_valid = 1'b0;
        o_resp_data       = '0;
        o_snoop_wnr       = 1'b0;
        o_snoop_addr      = '0;
        if (r_state == SNOOP) begin
            o_snoop_valid[w_other] = 1'b1;
            o_snoop_wnr            = r_wnr;
            o_snoop_addr           = r_addr;
        end
        if (r_state == DONE) begin
            o_req_ack[r_grant_id] = 1'b1;
            o_resp_hit            = r_resp.hit;
            o_resp_data_valid     = r_resp.dirty;
            o_resp_data           = r_resp.dirty ? r_resp.data : 32'd0;
        end
    end

    assign o_busy        = (r_state != IDLE);
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_l2_snoop_arbiter.sv
// tb/tb_l2_snoop_arbiter.sv - directed scoreboard bench for l2_snoop_arbiter
module tb_l2_snoop_arbiter;

    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_wnr, req_ack;
    logic [1:0][31:0] req_addr, snoop_data;
    logic [1:0]       snoop_valid, snoop_ack, snoop_hit, snoop_dirty;
    logic             resp_hit, resp_data_valid, snoop_wnr, busy, timeout_err;
    logic [31:0]      resp_data, snoop_addr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  ack;
        logic        hit;
        logic        dv;
        logic [31:0] data;
        logic        to;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    l2_snoop_arbiter #(.NUM_CPUS(2), .SNOOP_TIMEOUT(TO)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_valid       (req_valid),
        .i_req_wnr         (req_wnr),
        .i_req_addr        (req_addr),
        .o_req_ack         (req_ack),
        .o_resp_hit        (resp_hit),
        .o_resp_data_valid (resp_data_valid),
        .o_resp_data       (resp_data),
        .o_snoop_valid     (snoop_valid),
        .o_snoop_wnr       (snoop_wnr),
        .o_snoop_addr      (snoop_addr),
        .i_snoop_ack       (snoop_ack),
        .i_snoop_hit       (snoop_hit),
        .i_snoop_dirty     (snoop_dirty),
        .i_snoop_data      (snoop_data),
        .o_busy            (busy),
        .o_timeout_err     (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic h, input logic dv,
                        input logic [31:0] d, input logic to);
        exp_t e;
        e.ack = a; e.hit = h; e.dv = dv; e.data = dv ? d : 32'd0; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic give_ack(input logic core, input logic h, input logic d, input logic [31:0] data);
        snoop_ack         = 2'b00;
        snoop_ack[core]   = 1'b1;
        snoop_hit[core]   = h;
        snoop_dirty[core] = d;
        snoop_data[core]  = data;
    endtask

    task automatic serve_done(input string tag);
        exp_t e;
        chk({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_req_ack"}, 32'(req_ack), 32'(e.ack));
            chk({tag, "_resp_hit"}, 32'(resp_hit), 32'(e.hit));
            chk({tag, "_resp_dv"}, 32'(resp_data_valid), 32'(e.dv));
            chk({tag, "_resp_data"}, resp_data, e.data);
            chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(e.to));
        end
    endtask

    initial begin
        logic g;
        logic dv;
        rst = 1'b1; req_valid = '0; req_wnr = '0; req_addr = '0;
        snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_flags", 32'({req_ack, snoop_valid, resp_hit, resp_data_valid, snoop_wnr, busy, timeout_err}), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_snoop_addr", snoop_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single clean read from core 0
        req_valid = 2'b01; req_wnr = 2'b00; req_addr[0] = 32'h0000_1000;
        push(2'b01, 1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("rd_snoop_valid", 32'(snoop_valid), 32'd2);
        chk("rd_snoop_addr", snoop_addr, 32'h1000);
        chk("rd_snoop_wnr", 32'(snoop_wnr), 32'd0);
        give_ack(1'b1, 1'b1, 1'b0, 32'h5555_5555);
        @(negedge clk);
        snoop_ack = '0;
        serve_done("rd");
        req_valid = '0;

        // Dirty write from core 1
        @(negedge clk);
        req_valid = 2'b10; req_wnr = 2'b10; req_addr[1] = 32'h0000_2000;
        push(2'b10, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("wr_snoop_valid", 32'(snoop_valid), 32'd1);
        chk("wr_snoop_wnr", 32'(snoop_wnr), 32'd1);
        chk("wr_snoop_addr", snoop_addr, 32'h2000);
        give_ack(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        snoop_ack = '0;
        serve_done("wr");
        req_valid = '0; req_wnr = '0;

        // Contention straight after reset: grants 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_addr[0] = 32'h100; req_addr[1] = 32'h200; req_wnr = 2'b10; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            g  = i[0];
            dv = i[0];
            @(negedge clk);
            chk($sformatf("cont%0d_snoop_valid", i), 32'(snoop_valid), g ? 32'd1 : 32'd2);
            chk($sformatf("cont%0d_snoop_addr", i), snoop_addr, g ? 32'h200 : 32'h100);
            chk($sformatf("cont%0d_snoop_wnr", i), 32'(snoop_wnr), 32'(g));
            push(g ? 2'b10 : 2'b01, 1'b1, dv, 32'hA0 + 32'(i), 1'b0);
            give_ack(~g, 1'b1, dv, 32'hA0 + 32'(i));
            @(negedge clk);
            snoop_ack = '0;
            serve_done($sformatf("cont%0d", i));
            req_valid[g] = 1'b0;
            @(negedge clk);
            chk($sformatf("cont%0d_idle_gap", i), 32'(busy), 32'd0);
            if (i < 2) req_valid[g] = 1'b1;
        end

        // Timeout with no snoop_ack
        req_valid = 2'b01; req_wnr = 2'b00; req_addr[0] = 32'h3000;
        push(2'b01, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), 32'({req_ack, timeout_err, ~snoop_valid[1]}), 32'd0);
        end
        @(negedge clk);
        serve_done("to");
        req_valid = '0;
        @(negedge clk);
        chk("to_pulse_once", 32'(timeout_err), 32'd0);

        // Ack on the final count wins over the timeout
        req_valid = 2'b10; req_wnr = 2'b10; req_addr[1] = 32'h4000;
        push(2'b10, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            chk($sformatf("tolast_wait%0d", k), 32'({req_ack, timeout_err}), 32'd0);
        end
        @(negedge clk);
        give_ack(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
        @(negedge clk);
        snoop_ack = '0;
        serve_done("tolast");
        req_valid = '0; req_wnr = '0;

        // Spurious acks: in IDLE, then from the granted core
        @(negedge clk);
        snoop_ack = 2'b11; snoop_hit = 2'b11; snoop_dirty = 2'b11;
        repeat (2) begin
            @(negedge clk);
            chk("spur_idle", 32'({busy, req_ack, snoop_valid}), 32'd0);
        end
        snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0;
        req_valid = 2'b01; req_addr[0] = 32'h5000;
        push(2'b01, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("spur_snoop_valid", 32'(snoop_valid), 32'd2);
        snoop_ack = 2'b01; snoop_hit = 2'b01; snoop_dirty = 2'b01; snoop_data[0] = 32'h1111_2222;
        repeat (3) begin
            @(negedge clk);
            chk("spur_own", 32'({req_ack, snoop_valid, timeout_err}), 32'b00100);
        end
        give_ack(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        snoop_ack = '0;
        serve_done("spur");
        req_valid = '0;

        // Reset in the middle of SNOOP
        @(negedge clk);
        req_valid = 2'b10; req_wnr = 2'b10; req_addr[1] = 32'h6000;
        @(negedge clk);
        chk("mid_snoop_valid", 32'(snoop_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_flags", 32'({req_ack, snoop_valid, resp_hit, resp_data_valid, snoop_wnr, busy, timeout_err}), 32'd0);
        chk("rst_async_addr", snoop_addr, 32'd0);
        req_valid = '0; req_wnr = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_ack", 32'({req_ack, busy}), 32'd0);
        end
        req_valid = 2'b11; req_addr[0] = 32'h7000; req_addr[1] = 32'h7100;
        push(2'b01, 1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("rst_next_grant", 32'(snoop_valid), 32'd2);
        chk("rst_next_addr", snoop_addr, 32'h7000);
        give_ack(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        snoop_ack = '0;
        serve_done("post_rst");
        req_valid = '0;
        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
